axicb_slv_switch_wr: RTL and testbench
======================================

// Module: axicb_slv_switch_wr
// PURPOSE
//  Master-side write switch. Sits between one master port and SLV_NB master switches (axicb_mst_switch_wr).
//  Decodes AW address to one slave and routes W beats in AW order through a grant FIFO.
//  Arbitrates B responses from all slaves back to the master, round-robin.
//  Unmapped addresses get a locally generated DECERR.
// PARAMETERS
//  AXI_ADDR_W    16        address width; AWCH = {other, ADDR, ID}; ID at [0+:AXI_ID_W], ADDR next
//  AXI_ID_W      8         ID width; BCH = {RESP[1:0], ID}, BCH_W = AXI_ID_W+2
//  SLV_NB        4         number of slave outputs (1..4)
//  SLVx_START_ADDR / SLVx_END_ADDR  x=0..3, 'h0000+x*'h1000 / 'h0FFF+x*'h1000   inclusive decode window
//  WFIFO_DEPTH   8         W grant FIFO entries (power of 2)
//  MAX_OSTD      16        max outstanding AW (accepted, B not yet returned)
//  AWCH_W / WCH_W / BCH_W  32 / 8 / 10   concatenated channel widths
// PORTS
//  aclk       in   1               clock
//  aresetn    in   1               asynchronous active-low reset
//  i_awvalid  in   1               master AW valid
//  i_awready  out  1               master AW ready
//  i_awch     in   AWCH_W          master AW payload
//  i_wvalid   in   1               master W valid
//  i_wready   out  1               master W ready
//  i_wlast    in   1               master W last
//  i_wch      in   WCH_W           master W payload
//  i_bvalid   out  1               master B valid
//  i_bready   in   1               master B ready
//  i_bch      out  BCH_W           master B payload
//  o_awvalid  out  SLV_NB          per-slave AW valid
//  o_awready  in   SLV_NB          per-slave AW ready
//  o_awch     out  AWCH_W          AW payload broadcast to all slaves
//  o_wvalid   out  SLV_NB          per-slave W valid
//  o_wready   in   SLV_NB          per-slave W ready
//  o_wlast    out  1               W last broadcast
//  o_wch      out  WCH_W           W payload broadcast
//  o_bvalid   in   SLV_NB          per-slave B valid
//  o_bready   out  SLV_NB          per-slave B ready
//  o_bch      in   SLV_NB*BCH_W    per-slave B payload
// BEHAVIOUR
//  Reset (aresetn low, async): FIFO empty, ostd counter 0, RR pointer = slave 0, DECERR slot empty.
//   All valid/ready outputs are then 0.
//  AW decode: combinational, 0-cycle. sel = first slave whose window contains the address; none = decode error.
//  o_awvalid[sel] = i_awvalid & !stall; stall = fifo_full | (ostd==MAX_OSTD).
//   i_awready = o_awready[sel] & !stall.
//  Decode error: no o_awvalid asserted; i_awready = !stall & !derr_slot_full.
//   On handshake, ID is captured in the DECERR slot (single entry); further error AWs stall until its B completes.
//  AW handshake pushes {err, sel_onehot} into the W FIFO (registered, not pass-through).
//   W for a burst may start no earlier than the cycle after its AW handshake.
//  W path: head entry selects target. o_wvalid[head] = i_wvalid & !empty; i_wready = o_wready[head] & !empty.
//   FIFO empty: i_wready=0, all o_wvalid=0 (W ahead of AW waits).
//   err head: i_wready = !empty, beats discarded; wlast handshake marks DECERR slot ready to respond.
//   Pop on wlast handshake only; back-to-back bursts to different slaves need no idle cycle.
//  B arbitration: requestors = o_bvalid[SLV_NB-1:0] plus DECERR slot (index SLV_NB, ready only after its wlast).
//   Round-robin from pointer; grant is locked while i_bvalid & !i_bready (no switch, payload stable).
//   i_bvalid = valid of granted source; i_bch = its payload (DECERR: RESP=2'b11, captured ID).
//   o_bready[g] = i_bready for granted g only. On handshake, pointer = g+1 mod (SLV_NB+1).
//  ostd counter: +1 on AW handshake, -1 on B handshake, same cycle = unchanged.
//   Saturates at MAX_OSTD (AW stalled); never underflows.
//  FIFO full + pop same cycle: no push that cycle (full gates ready). FIFO pointers wrap mod WFIFO_DEPTH.
//  aresetn asserted mid-burst: all state cleared immediately; partial bursts dropped; no response owed after release.
// TESTING
//  AW addr 'h1234, then 4-beat W -> o_awvalid=4'b0010, W beats on o_wvalid[1]; B from slv1 forwarded, ostd 1->0.
//  AW addr 'hF000 (unmapped) ID 'h5A, 2 beats -> no o_awvalid, W absorbed; then i_bch={2'b11,'h5A}, i_bvalid=1.
//  W valid 3 cycles before AW (slv2) -> i_wready=0 until cycle after AW handshake, then beats go to slv2.
//  o_bvalid=4'b0101 same cycle, i_bready low 2 cycles -> slv0 granted and held stable, then slv2 next.
//  17 AWs, no B returned -> 16 accepted, i_awready=0 on 17th; one B handshake -> 17th accepted next cycle.
//  aresetn low mid-burst to slv3 -> all o_*valid=0 same cycle; after release FIFO empty, ostd=0, fresh AW routes.

Source files
------------

// File: rtl/axicb_slv_switch_wr.sv
`default_nettype none
// ============================================================================
// Module   : axicb_slv_switch_wr
// Purpose  : Master-side AXI write switch: AW decode, W routing, B round-robin
// Revision : 1.0
// ============================================================================
module axicb_slv_switch_wr #(
    parameter int                    AXI_ADDR_W      = 16,
    parameter int                    AXI_ID_W        = 8,
    parameter int                    SLV_NB          = 4,
    parameter logic [AXI_ADDR_W-1:0] SLV0_START_ADDR = 'h0000,
    parameter logic [AXI_ADDR_W-1:0] SLV0_END_ADDR   = 'h0FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV1_START_ADDR = 'h1000,
    parameter logic [AXI_ADDR_W-1:0] SLV1_END_ADDR   = 'h1FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV2_START_ADDR = 'h2000,
    parameter logic [AXI_ADDR_W-1:0] SLV2_END_ADDR   = 'h2FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV3_START_ADDR = 'h3000,
    parameter logic [AXI_ADDR_W-1:0] SLV3_END_ADDR   = 'h3FFF,
    parameter int                    WFIFO_DEPTH     = 8,
    parameter int                    MAX_OSTD        = 16,
    parameter int                    AWCH_W          = 32,
    parameter int                    WCH_W           = 8,
    parameter int                    BCH_W           = 10
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     i_awvalid,
    output logic                     i_awready,
    input  logic [AWCH_W-1:0]        i_awch,
    input  logic                     i_wvalid,
    output logic                     i_wready,
    input  logic                     i_wlast,
    input  logic [WCH_W-1:0]         i_wch,
    output logic                     i_bvalid,
    input  logic                     i_bready,
    output logic [BCH_W-1:0]         i_bch,
    output logic [SLV_NB-1:0]        o_awvalid,
    input  logic [SLV_NB-1:0]        o_awready,
    output logic [AWCH_W-1:0]        o_awch,
    output logic [SLV_NB-1:0]        o_wvalid,
    input  logic [SLV_NB-1:0]        o_wready,
    output logic                     o_wlast,
    output logic [WCH_W-1:0]         o_wch,
    input  logic [SLV_NB-1:0]        o_bvalid,
    output logic [SLV_NB-1:0]        o_bready,
    input  logic [SLV_NB*BCH_W-1:0]  o_bch
);

    localparam int C_PTR_W  = $clog2(WFIFO_DEPTH);
    localparam int C_OSTD_W = $clog2(MAX_OSTD + 1);
    localparam int C_NREQ   = SLV_NB + 1;
    localparam int C_GNT_W  = $clog2(C_NREQ);
    localparam logic [C_PTR_W:0]      C_DEPTH    = (C_PTR_W + 1)'(WFIFO_DEPTH);
    localparam logic [C_OSTD_W-1:0]   C_MAX_OSTD = C_OSTD_W'(MAX_OSTD);
    localparam logic [C_GNT_W-1:0]    C_DERR_IDX = C_GNT_W'(SLV_NB);
    localparam logic [AXI_ADDR_W-1:0] C_START [4] = '{SLV0_START_ADDR, SLV1_START_ADDR,
                                                      SLV2_START_ADDR, SLV3_START_ADDR};
    localparam logic [AXI_ADDR_W-1:0] C_END   [4] = '{SLV0_END_ADDR, SLV1_END_ADDR,
                                                      SLV2_END_ADDR, SLV3_END_ADDR};

    logic [AXI_ADDR_W-1:0] w_addr;
    logic [SLV_NB-1:0]     w_sel;
    logic                  w_hit;
    logic                  w_stall;
    logic                  w_aw_hs;
    logic                  w_full;
    logic                  w_empty;
    logic [SLV_NB:0]       w_head;
    logic                  w_head_err;
    logic [SLV_NB-1:0]     w_head_sel;
    logic                  w_w_hs;
    logic                  w_pop;
    logic [C_NREQ-1:0]     w_breq;
    logic [C_GNT_W-1:0]    w_rr_gnt;
    logic                  w_rr_hit;
    logic [C_GNT_W-1:0]    w_gnt;
    logic                  w_bvalid;
    logic [BCH_W-1:0]      w_bch;
    logic [SLV_NB-1:0]     w_bready;
    logic                  w_b_hs;

    logic [SLV_NB:0]       r_fifo [WFIFO_DEPTH];
    logic [C_PTR_W-1:0]    r_wptr;
    logic [C_PTR_W-1:0]    r_rptr;
    logic [C_PTR_W:0]      r_cnt;
    logic [C_OSTD_W-1:0]   r_ostd;
    logic                  r_derr_full;
    logic                  r_derr_rdy;
    logic [AXI_ID_W-1:0]   r_derr_id;
    logic [C_GNT_W-1:0]    r_ptr;
    logic [C_GNT_W-1:0]    r_gnt;
    logic                  r_lock;

    // Lowest-index window wins when windows overlap
    assign w_addr = i_awch[AXI_ID_W +: AXI_ADDR_W];
    always_comb begin
        w_sel = '0;
        w_hit = 1'b0;
        for (int i = 0; i < SLV_NB; i++) begin
            if (!w_hit && (w_addr >= C_START[i]) && (w_addr <= C_END[i])) begin
                w_sel[i] = 1'b1;
                w_hit    = 1'b1;
            end
        end
    end

    assign w_full    = (r_cnt == C_DEPTH);
    assign w_empty   = (r_cnt == '0);
    assign w_stall   = w_full | (r_ostd == C_MAX_OSTD);
    assign o_awvalid = {SLV_NB{i_awvalid & ~w_stall & w_hit}} & w_sel;
    assign i_awready = w_hit ? ((|(o_awready & w_sel)) & ~w_stall)
                             : (~w_stall & ~r_derr_full);
    assign w_aw_hs   = i_awvalid & i_awready;
    assign o_awch    = i_awch;

    // Head of the grant FIFO steers W; error bursts are swallowed locally
    assign w_head     = r_fifo[r_rptr];
    assign w_head_err = w_head[SLV_NB];
    assign w_head_sel = w_head[SLV_NB-1:0];
    assign o_wvalid   = {SLV_NB{i_wvalid & ~w_empty & ~w_head_err}} & w_head_sel;
    assign i_wready   = ~w_empty & (w_head_err | (|(o_wready & w_head_sel)));
    assign w_w_hs     = i_wvalid & i_wready;
    assign w_pop      = w_w_hs & i_wlast;
    assign o_wlast    = i_wlast;
    assign o_wch      = i_wch;

    always_ff @(posedge aclk) begin
        if (w_aw_hs) begin
            r_fifo[r_wptr] <= {~w_hit, w_sel};
        end
    end

    assign w_breq = {r_derr_full & r_derr_rdy, o_bvalid};

    // Round-robin: first scan from the pointer upward, then wrap to the low indices
    always_comb begin
        w_rr_gnt = r_ptr;
        w_rr_hit = 1'b0;
        for (int j = 0; j < C_NREQ; j++) begin
            if (!w_rr_hit && (C_GNT_W'(j) >= r_ptr) && w_breq[j]) begin
                w_rr_gnt = C_GNT_W'(j);
                w_rr_hit = 1'b1;
            end
        end
        for (int j = 0; j < C_NREQ; j++) begin
            if (!w_rr_hit && w_breq[j]) begin
                w_rr_gnt = C_GNT_W'(j);
                w_rr_hit = 1'b1;
            end
        end
    end

    assign w_gnt = r_lock ? r_gnt : w_rr_gnt;

    always_comb begin
        w_bvalid = 1'b0;
        w_bch    = '0;
        w_bready = '0;
        for (int j = 0; j < SLV_NB; j++) begin
            if (w_gnt == C_GNT_W'(j)) begin
                w_bvalid    = o_bvalid[j];
                w_bch       = o_bch[j*BCH_W +: BCH_W];
                w_bready[j] = i_bready;
            end
        end
        if (w_gnt == C_DERR_IDX) begin
            w_bvalid = r_derr_full & r_derr_rdy;
            w_bch    = {2'b11, r_derr_id};
        end
    end

    assign i_bvalid = w_bvalid;
    assign i_bch    = w_bch;
    assign o_bready = w_bready;
    assign w_b_hs   = w_bvalid & i_bready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_ostd      <= '0;
            r_derr_full <= 1'b0;
            r_derr_rdy  <= 1'b0;
            r_derr_id   <= '0;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_lock      <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_aw_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            case ({w_aw_hs, w_b_hs})
                2'b10:   r_ostd <= r_ostd + 1'b1;
                2'b01:   r_ostd <= (r_ostd != '0) ? r_ostd - 1'b1 : r_ostd;
                default: r_ostd <= r_ostd;
            endcase

            if (w_aw_hs && !w_hit) begin
                r_derr_full <= 1'b1;
                r_derr_id   <= i_awch[AXI_ID_W-1:0];
            end
            if (w_pop && w_head_err) begin
                r_derr_rdy <= 1'b1;
            end
            if (w_b_hs && (w_gnt == C_DERR_IDX)) begin
                r_derr_full <= 1'b0;
                r_derr_rdy  <= 1'b0;
            end

            // Hold the grant while a response is stalled so the payload stays stable
            if (w_b_hs) begin
                r_lock <= 1'b0;
                r_ptr  <= (w_gnt == C_DERR_IDX) ? '0 : w_gnt + 1'b1;
            end else if (w_bvalid) begin
                r_lock <= 1'b1;
                r_gnt  <= w_gnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axicb_slv_switch_wr.sv
`default_nettype none
// Testbench for axicb_slv_switch_wr: directed scenarios plus randomized transactions
`timescale 1ns/1ps
module tb_axicb_slv_switch_wr;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        awvalid, awready;
    logic [31:0] awch;
    logic        wvalid, wready, wlast;
    logic [7:0]  wch;
    logic        bvalid, bready;
    logic [9:0]  bch;
    logic [3:0]  s_awvalid, s_awready;
    logic [31:0] s_awch;
    logic [3:0]  s_wvalid, s_wready;
    logic        s_wlast;
    logic [7:0]  s_wch;
    logic [3:0]  s_bvalid, s_bready;
    logic [39:0] s_bch;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 aclk = ~aclk;

    axicb_slv_switch_wr dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_awvalid (awvalid),
        .i_awready (awready),
        .i_awch    (awch),
        .i_wvalid  (wvalid),
        .i_wready  (wready),
        .i_wlast   (wlast),
        .i_wch     (wch),
        .i_bvalid  (bvalid),
        .i_bready  (bready),
        .i_bch     (bch),
        .o_awvalid (s_awvalid),
        .o_awready (s_awready),
        .o_awch    (s_awch),
        .o_wvalid  (s_wvalid),
        .o_wready  (s_wready),
        .o_wlast   (s_wlast),
        .o_wch     (s_wch),
        .o_bvalid  (s_bvalid),
        .o_bready  (s_bready),
        .o_bch     (s_bch)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: 4 KiB windows starting at 0, four slaves, everything else unmapped
    function automatic int dec(input logic [15:0] a);
        return (a < 16'h4000) ? int'(a[15:12]) : -1;
    endfunction

    function automatic logic [3:0] oh(input int t);
        return (t < 0) ? 4'b0000 : 4'(1 << t);
    endfunction

    function automatic int rr_pick(input logic [4:0] req, input int ptr);
        for (int k = 0; k < 5; k++) begin
            int idx;
            idx = (ptr + k) % 5;
            if (req[idx[2:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_send(input logic [15:0] addr, input logic [7:0] id);
        int n;
        n = 0;
        awvalid = 1'b1;
        awch    = {8'hC3, addr, id};
        #1;
        while (!awready && n < 40) begin
            tick();
            n++;
        end
        chk("aw_wait", 64'(n < 40), 64'd1);
        chk("aw_route", 64'(s_awvalid), 64'(oh(dec(addr))));
        chk("aw_bcast", 64'(s_awch), 64'(awch));
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_send(input int len, input int tgt);
        for (int b = 0; b < len; b++) begin
            int n;
            n = 0;
            wvalid   = 1'b1;
            wlast    = (b == len - 1);
            wch      = 8'($urandom);
            s_wready = 4'($urandom);
            #1;
            while (!wready && n < 40) begin
                tick();
                s_wready = 4'($urandom) | ((n > 3) ? 4'hF : 4'h0);
                #1;
                n++;
            end
            chk("w_wait", 64'(n < 40), 64'd1);
            chk("w_route", 64'(s_wvalid), 64'(oh(tgt)));
            chk("w_data", 64'({s_wlast, s_wch}), 64'({wlast, wch}));
            tick();
        end
        wvalid   = 1'b0;
        wlast    = 1'b0;
        s_wready = 4'hF;
    endtask

    task automatic b_resp(input int tgt, input logic [7:0] id);
        logic [1:0] resp;
        logic [9:0] exp;
        int n;
        resp = 2'($urandom);
        n = 0;
        s_bch = '0;
        if (tgt >= 0) begin
            s_bvalid = oh(tgt);
            s_bch[tgt*10 +: 10] = {resp, id};
            exp = {resp, id};
        end else begin
            s_bvalid = 4'b0000;
            exp = {2'b11, id};
        end
        bready = 1'b1;
        #1;
        while (!bvalid && n < 40) begin
            tick();
            n++;
        end
        chk("b_valid", 64'(bvalid), 64'd1);
        chk("b_payload", 64'(bch), 64'(exp));
        chk("b_ready", 64'(s_bready), 64'(oh(tgt)));
        tick();
        m_ptr    = (((tgt < 0) ? 4 : tgt) + 1) % 5;
        s_bvalid = 4'b0000;
        bready   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int g2;
        logic [15:0] ra;
        logic [7:0]  rid;
        int          rlen;

        awvalid = 0; awch = '0; wvalid = 0; wlast = 0; wch = '0; bready = 0;
        s_awready = 4'h0; s_wready = 4'h0; s_bvalid = 4'h0; s_bch = '0;

        // Reset state
        #2 aresetn = 1'b0;
        #1;
        chk("rst_awvalid", 64'(s_awvalid), 64'd0);
        chk("rst_wvalid", 64'(s_wvalid), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_bready", 64'(s_bready), 64'd0);
        repeat (3) tick();
        aresetn = 1'b1;
        s_awready = 4'hF;
        s_wready  = 4'hF;
        tick();

        // Mapped burst to slave 1
        aw_send(16'h1234, 8'h11);
        w_send(4, 1);
        b_resp(1, 8'h11);

        // Unmapped burst gets a local DECERR
        aw_send(16'hF000, 8'h5A);
        w_send(2, -1);
        b_resp(-1, 8'h5A);

        // W presented before its AW must wait for the cycle after the handshake
        wvalid = 1'b1; wlast = 1'b1; wch = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("early_w_ready", 64'(wready), 64'd0);
            chk("early_w_valid", 64'(s_wvalid), 64'd0);
            tick();
        end
        awvalid = 1'b1; awch = {8'hC3, 16'h2010, 8'h3C};
        #1;
        chk("early_aw_ready", 64'(awready), 64'd1);
        chk("early_aw_route", 64'(s_awvalid), 64'h4);
        chk("early_w_same_cyc", 64'(wready), 64'd0);
        tick();
        awvalid = 1'b0;
        chk("early_w_next_rdy", 64'(wready), 64'd1);
        chk("early_w_next_vld", 64'(s_wvalid), 64'h4);
        chk("early_w_data", 64'(s_wch), 64'hA5);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        b_resp(2, 8'h3C);

        // Simultaneous B from slaves 0 and 2 with a stalled master
        aw_send(16'h0040, 8'h21); w_send(1, 0);
        aw_send(16'h2200, 8'h22); w_send(1, 2);
        s_bch = '0;
        s_bch[9:0]   = {2'b01, 8'h21};
        s_bch[29:20] = {2'b10, 8'h22};
        s_bvalid = 4'b0101;
        bready   = 1'b0;
        g = rr_pick({1'b0, s_bvalid}, m_ptr);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("arb_hold_valid", 64'(bvalid), 64'd1);
            chk("arb_hold_payload", 64'(bch), 64'(s_bch[g*10 +: 10]));
            chk("arb_hold_bready", 64'(s_bready), 64'd0);
            tick();
        end
        bready = 1'b1;
        #1;
        chk("arb_first_payload", 64'(bch), 64'(s_bch[g*10 +: 10]));
        chk("arb_first_bready", 64'(s_bready), 64'(oh(g)));
        tick();
        m_ptr = (g + 1) % 5;
        s_bvalid[g] = 1'b0;
        g2 = rr_pick({1'b0, s_bvalid}, m_ptr);
        #1;
        chk("arb_second_valid", 64'(bvalid), 64'd1);
        chk("arb_second_payload", 64'(bch), 64'(s_bch[g2*10 +: 10]));
        chk("arb_second_bready", 64'(s_bready), 64'(oh(g2)));
        tick();
        m_ptr = (g2 + 1) % 5;
        s_bvalid = 4'b0000;
        bready = 1'b0;

        // Outstanding limit: 16 accepted, 17th stalls until one B completes
        for (int k = 0; k < 16; k++) begin
            aw_send(16'((k % 4) << 12) | 16'h0010, 8'(k));
            w_send(1, k % 4);
        end
        awvalid = 1'b1; awch = {8'hC3, 16'h1000, 8'h77};
        #1;
        chk("ostd_stall_ready", 64'(awready), 64'd0);
        chk("ostd_stall_route", 64'(s_awvalid), 64'd0);
        tick();
        chk("ostd_stall_ready2", 64'(awready), 64'd0);
        s_bch = '0;
        s_bvalid = 4'b0001;
        bready = 1'b1;
        #1;
        chk("ostd_b_valid", 64'(bvalid), 64'd1);
        chk("ostd_b_same_cyc", 64'(awready), 64'd0);
        tick();
        s_bvalid = 4'b0000; bready = 1'b0; m_ptr = 1;
        #1;
        chk("ostd_release_ready", 64'(awready), 64'd1);
        chk("ostd_release_route", 64'(s_awvalid), 64'h2);
        tick();
        awvalid = 1'b0;
        w_send(1, 1);
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < ((t == 0) ? 3 : (t == 1) ? 5 : 4); c++) begin
                b_resp(t, 8'(c));
            end
        end

        // Reset in the middle of a burst to slave 3
        aw_send(16'h3456, 8'h33);
        wvalid = 1'b1; wlast = 1'b0; wch = 8'h99; s_wready = 4'hF;
        #1;
        chk("mid_w_route", 64'(s_wvalid), 64'h8);
        tick();
        aresetn = 1'b0;
        #1;
        chk("mid_rst_wvalid", 64'(s_wvalid), 64'd0);
        chk("mid_rst_wready", 64'(wready), 64'd0);
        chk("mid_rst_awvalid", 64'(s_awvalid), 64'd0);
        chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
        tick();
        tick();
        aresetn = 1'b1;
        m_ptr = 0;
        tick();
        chk("post_rst_wready", 64'(wready), 64'd0);
        wvalid = 1'b0;
        aw_send(16'h0100, 8'h44);
        w_send(2, 0);
        b_resp(0, 8'h44);

        // Randomized transactions against the reference decode
        for (int t = 0; t < 25; t++) begin
            ra   = 16'($urandom_range(0, 32'h5FFF));
            rid  = 8'($urandom);
            rlen = int'($urandom_range(1, 4));
            aw_send(ra, rid);
            w_send(rlen, dec(ra));
            b_resp(dec(ra), rid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
